// File: rtl/grid_actor_if.sv
// grid_actor_if: command/status bundle between input decoders, grid_actor_ctrl and arena logic
//   wall_map                 static wall map, bit r*COLS+c
//   cmd_valid/cmd_op         per-player command request, 3-bit opcode per lane
//   cmd_ready/cmd_reject     per-player consume / illegal-command pulses
//   pos_r/pos_c              4-bit row/column per player
//   bomb_map                 live or pending bomb per cell
//   explode_valid/idx/owner  one-cycle explosion event
interface grid_actor_if #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int NPLAYERS = 2
);
    logic [ROWS*COLS-1:0]  wall_map;
    logic [NPLAYERS-1:0]   cmd_valid;
    logic [3*NPLAYERS-1:0] cmd_op;
    logic [NPLAYERS-1:0]   cmd_ready;
    logic [NPLAYERS-1:0]   cmd_reject;
    logic [4*NPLAYERS-1:0] pos_r;
    logic [4*NPLAYERS-1:0] pos_c;
    logic [ROWS*COLS-1:0]  bomb_map;
    logic                  explode_valid;
    logic [7:0]            explode_idx;
    logic [1:0]            explode_owner;
    modport master (
        output wall_map, cmd_valid, cmd_op,
        input  cmd_ready, cmd_reject, pos_r, pos_c, bomb_map, explode_valid, explode_idx, explode_owner
    );
    modport slave (
        input  wall_map, cmd_valid, cmd_op,
        output cmd_ready, cmd_reject, pos_r, pos_c, bomb_map, explode_valid, explode_idx, explode_owner
    );
endinterface

// File: rtl/grid_actor_ctrl.sv
// grid_actor_ctrl: owns player positions and bombs in a ROWS x COLS arena, arbitrates commands, runs fuses
//   clk, rst  clock, asynchronous active-high reset
//   bus       grid_actor_if.slave: wall map and per-player commands in; ready/reject,
//             positions, bomb map and explosion events out
module grid_actor_ctrl #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int NPLAYERS = 2,
    parameter int MAX_BOMBS = 1,
    parameter int FUSE = 48,
    parameter int COOLDOWN = 8
) (
    input logic clk,
    input logic rst,
    grid_actor_if.slave bus
);
    localparam int N = ROWS*COLS;
    localparam int NS = NPLAYERS*MAX_BOMBS;
    localparam int CW = $clog2(COOLDOWN+2);
    localparam int FW = $clog2(FUSE+1);

    logic [3:0]    pr [NPLAYERS];
    logic [3:0]    pc [NPLAYERS];
    logic [CW-1:0] cd [NPLAYERS];
    logic [1:0]    ptr;
    logic [NS-1:0] s_used, s_pend;
    logic [7:0]    s_cell [NS];
    logic [1:0]    s_own [NS];
    logic [FW-1:0] s_fuse [NS];
    logic          ex_v;
    logic [7:0]    ex_idx;
    logic [1:0]    ex_own;

    logic [N-1:0]  bm, tmask, hmask;
    logic          gv, mv, inb, occ, legal;
    logic [1:0]    g;
    logic [2:0]    op;
    logic [3:0]    gr, gc, tr, tc;
    int            cnt, e, fs;

    function automatic logic [3:0] init_r(int p);
        return (p == 1 || p == 3) ? 4'(ROWS-1) : 4'd0;
    endfunction

    function automatic logic [3:0] init_c(int p);
        return (p == 1 || p == 2) ? 4'(COLS-1) : 4'd0;
    endfunction

    // Occupancy includes pending slots, so a cell stays blocked until its explosion edge.
    always_comb begin
        bm = '0;
        for (int i = 0; i < NS; i++)
            if (s_used[i]) bm = bm | (N'(1) << s_cell[i]);
    end

    always_comb begin
        gv = 1'b0;
        g = '0;
        op = '0;
        gr = '0;
        gc = '0;
        occ = 1'b0;
        cnt = 0;
        e = -1;
        fs = -1;
        // Round-robin: scan players in order ptr, ptr+1, ... and take the first eligible one.
        for (int k = 0; k < NPLAYERS; k++)
            for (int p = 0; p < NPLAYERS; p++)
                if (!gv && !rst && p == (int'(ptr) + k) % NPLAYERS && bus.cmd_valid[p] && cd[p] == '0) begin
                    gv = 1'b1;
                    g = 2'(p);
                end
        for (int p = 0; p < NPLAYERS; p++)
            if (gv && g == 2'(p)) begin
                op = bus.cmd_op[3*p +: 3];
                gr = pr[p];
                gc = pc[p];
            end
        mv = op >= 3'd1 && op <= 3'd4;
        tr = op == 3'd1 ? gr - 4'd1 : op == 3'd2 ? gr + 4'd1 : gr;
        tc = op == 3'd3 ? gc - 4'd1 : op == 3'd4 ? gc + 4'd1 : gc;
        inb = op == 3'd1 ? gr != 4'd0 : op == 3'd2 ? gr != 4'(ROWS-1) :
              op == 3'd3 ? gc != 4'd0 : op == 3'd4 ? gc != 4'(COLS-1) : 1'b0;
        tmask = N'(1) << (int'(tr)*COLS + int'(tc));
        hmask = N'(1) << (int'(gr)*COLS + int'(gc));
        for (int p = 0; p < NPLAYERS; p++)
            if (2'(p) != g && pr[p] == tr && pc[p] == tc) occ = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (s_used[i] && s_own[i] == g) cnt = cnt + 1;
            if (fs < 0 && !s_used[i]) fs = i;
            if (e < 0 && s_pend[i]) e = i;
        end
        legal = mv ? inb && !(|(tmask & (bus.wall_map | bm))) && !occ :
                op == 3'd5 ? cnt < MAX_BOMBS && !(|(hmask & bm)) : 1'b0;
        bus.cmd_ready = gv ? NPLAYERS'(1) << g : '0;
        bus.cmd_reject = legal ? '0 : bus.cmd_ready;
    end

    always_comb begin
        bus.pos_r = '0;
        bus.pos_c = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            bus.pos_r[4*p +: 4] = pr[p];
            bus.pos_c[4*p +: 4] = pc[p];
        end
    end

    assign bus.bomb_map = bm;
    assign bus.explode_valid = ex_v;
    assign bus.explode_idx = ex_idx;
    assign bus.explode_owner = ex_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NPLAYERS; p++) begin
                pr[p] <= init_r(p);
                pc[p] <= init_c(p);
                cd[p] <= '0;
            end
            ptr <= '0;
            s_used <= '0;
            s_pend <= '0;
            for (int i = 0; i < NS; i++) begin
                s_cell[i] <= '0;
                s_own[i] <= '0;
                s_fuse[i] <= '0;
            end
            ex_v <= 1'b0;
            ex_idx <= '0;
            ex_own <= '0;
        end else begin
            ex_v <= e >= 0;
            if (gv) ptr <= 2'((int'(g) + 1) % NPLAYERS);
            for (int p = 0; p < NPLAYERS; p++)
                if (gv && legal && mv && g == 2'(p)) begin
                    pr[p] <= tr;
                    pc[p] <= tc;
                    cd[p] <= CW'(COOLDOWN);
                end else if (cd[p] != '0) cd[p] <= cd[p] - 1'b1;
            // The free slot is always unused, so it never collides with the exploding one.
            for (int i = 0; i < NS; i++)
                if (e == i) begin
                    ex_idx <= s_cell[i];
                    ex_own <= s_own[i];
                    s_used[i] <= 1'b0;
                    s_pend[i] <= 1'b0;
                end else if (gv && legal && op == 3'd5 && fs == i) begin
                    s_used[i] <= 1'b1;
                    s_pend[i] <= 1'b0;
                    s_cell[i] <= 8'(int'(gr)*COLS + int'(gc));
                    s_own[i] <= g;
                    s_fuse[i] <= FW'(FUSE);
                end else if (s_used[i] && !s_pend[i]) begin
                    s_pend[i] <= s_fuse[i] == FW'(1);
                    s_fuse[i] <= s_fuse[i] - 1'b1;
                end
        end
    end
endmodule

// File: tb/tb_grid_actor_ctrl.sv
// tb_grid_actor_ctrl: directed bench for grid_actor_ctrl (default build and a COOLDOWN=0 / MAX_BOMBS=2 / FUSE=6 build)
module tb_grid_actor_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [99:0] bm_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grid_actor_if #(.ROWS(10), .COLS(10), .NPLAYERS(2)) ia ();
    grid_actor_if #(.ROWS(10), .COLS(10), .NPLAYERS(2)) ib ();

    grid_actor_ctrl #(.ROWS(10), .COLS(10), .NPLAYERS(2), .MAX_BOMBS(1), .FUSE(48), .COOLDOWN(8))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    grid_actor_ctrl #(.ROWS(10), .COLS(10), .NPLAYERS(2), .MAX_BOMBS(2), .FUSE(6), .COOLDOWN(0))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    // Issue a player-0 command on dut_a, wait (bounded) for ready, return the reject flag.
    task automatic send_a(input logic [2:0] op, output logic rej);
        int n = 0;
        ia.cmd_valid[0] = 1'b1;
        ia.cmd_op[2:0] = op;
        #1;
        while (!ia.cmd_ready[0] && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n == 40) begin
            errors++;
            $display("FAIL send_timeout op %0d got no ready required ready within 40 cycles", op);
        end
        rej = ia.cmd_reject[0];
        @(posedge clk);
        #1;
        ia.cmd_valid[0] = 1'b0;
    endtask

    task automatic test_reset;
        ia.cmd_valid = '0;
        ia.cmd_op = '0;
        ia.wall_map = '0;
        ia.wall_map[1] = 1'b1;
        ib.cmd_valid = '0;
        ib.cmd_op = '0;
        ib.wall_map = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ia.pos_r !== 8'h90 || ia.pos_c !== 8'h90) begin errors++; $display("FAIL reset_pos got r=%h c=%h required r=90 c=90", ia.pos_r, ia.pos_c); end
        checks++;
        if (ia.bomb_map !== '0 || ib.bomb_map !== '0) begin errors++; $display("FAIL reset_bomb_map got a=%h b=%h required 0", ia.bomb_map, ib.bomb_map); end
        checks++;
        if (ia.cmd_ready !== 2'b00 || ia.cmd_reject !== 2'b00 || ia.explode_valid !== 1'b0) begin errors++; $display("FAIL reset_ctrl got ready=%b reject=%b explode=%b required 0", ia.cmd_ready, ia.cmd_reject, ia.explode_valid); end
        checks++;
        if (ib.pos_r !== 8'h90 || ib.pos_c !== 8'h90) begin errors++; $display("FAIL reset_pos_b got r=%h c=%h required r=90 c=90", ib.pos_r, ib.pos_c); end
        rst = 1'b0;
    endtask

    task automatic test_boundary;
        logic rej;
        send_a(3'd1, rej);
        checks++;
        if (rej !== 1'b1) begin errors++; $display("FAIL bound_up reject got %b required 1", rej); end
        send_a(3'd3, rej);
        checks++;
        if (rej !== 1'b1) begin errors++; $display("FAIL bound_left reject got %b required 1", rej); end
        send_a(3'd4, rej);
        checks++;
        if (rej !== 1'b1) begin errors++; $display("FAIL wall_right reject got %b required 1", rej); end
        send_a(3'd0, rej);
        checks++;
        if (rej !== 1'b1) begin errors++; $display("FAIL op0 reject got %b required 1", rej); end
        checks++;
        if (ia.pos_r[3:0] !== 4'd0 || ia.pos_c[3:0] !== 4'd0) begin errors++; $display("FAIL bound_pos got (%0d,%0d) required (0,0)", ia.pos_r[3:0], ia.pos_c[3:0]); end
    endtask

    task automatic test_move;
        logic rej;
        ia.cmd_valid = 2'b01;
        ia.cmd_op = {3'd0, 3'd2};
        #1;
        checks++;
        if (ia.cmd_ready !== 2'b01 || ia.cmd_reject !== 2'b00) begin errors++; $display("FAIL move_ready got ready=%b reject=%b required 01/00", ia.cmd_ready, ia.cmd_reject); end
        @(posedge clk);
        #1;
        checks++;
        if (ia.pos_r[3:0] !== 4'd1 || ia.pos_c[3:0] !== 4'd0) begin errors++; $display("FAIL move_pos got (%0d,%0d) required (1,0)", ia.pos_r[3:0], ia.pos_c[3:0]); end
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ia.cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL cooldown_block cycle %0d got ready %b required 0", i + 1, ia.cmd_ready[0]); end
            @(posedge clk);
            #1;
        end
        #1;
        checks++;
        if (ia.cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL cooldown_release got ready %b required 1", ia.cmd_ready[0]); end
        @(posedge clk);
        #1;
        ia.cmd_valid = 2'b00;
        checks++;
        if (ia.pos_r[3:0] !== 4'd2) begin errors++; $display("FAIL move2_pos got row %0d required 2", ia.pos_r[3:0]); end
        send_a(3'd1, rej);
        checks++;
        if (rej !== 1'b0 || ia.pos_r[3:0] !== 4'd1) begin errors++; $display("FAIL move_back got reject=%b row=%0d required 0/1", rej, ia.pos_r[3:0]); end
    endtask

    task automatic test_bomb;
        logic rej;
        int place, n_ex, at, idx, own;
        send_a(3'd5, rej);
        place = cyc;
        bm_exp = '0;
        bm_exp[10] = 1'b1;
        checks++;
        if (rej !== 1'b0 || ia.bomb_map !== bm_exp) begin errors++; $display("FAIL bomb_place got reject=%b map=%h required 0/%h", rej, ia.bomb_map, bm_exp); end
        send_a(3'd5, rej);
        checks++;
        if (rej !== 1'b1) begin errors++; $display("FAIL bomb_second reject got %b required 1", rej); end
        send_a(3'd2, rej);
        checks++;
        if (rej !== 1'b0 || ia.pos_r[3:0] !== 4'd2) begin errors++; $display("FAIL leave_bomb got reject=%b row=%0d required 0/2", rej, ia.pos_r[3:0]); end
        send_a(3'd1, rej);
        checks++;
        if (rej !== 1'b1 || ia.pos_r[3:0] !== 4'd2) begin errors++; $display("FAIL enter_bomb got reject=%b row=%0d required 1/2", rej, ia.pos_r[3:0]); end
        n_ex = 0;
        at = 0;
        idx = 0;
        own = 0;
        while (cyc < place + 60) begin
            if (ia.explode_valid) begin
                n_ex++;
                at = cyc - place;
                idx = ia.explode_idx;
                own = ia.explode_owner;
                checks++;
                if (ia.bomb_map !== '0) begin errors++; $display("FAIL explode_clear got map=%h required 0", ia.bomb_map); end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_ex !== 1) begin errors++; $display("FAIL explode_count got %0d required 1", n_ex); end
        checks++;
        if (at !== 49 || idx !== 10 || own !== 0) begin errors++; $display("FAIL explode_event got at=%0d idx=%0d owner=%0d required 49/10/0", at, idx, own); end
        send_a(3'd5, rej);
        bm_exp = '0;
        bm_exp[20] = 1'b1;
        checks++;
        if (rej !== 1'b0 || ia.bomb_map !== bm_exp) begin errors++; $display("FAIL bomb_replace got reject=%b map=%h required 0/%h", rej, ia.bomb_map, bm_exp); end
    endtask

    task automatic test_contention;
        ib.cmd_valid = 2'b11;
        ib.cmd_op = {3'd1, 3'd2};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ib.cmd_ready !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant cycle %0d got %b required %b", i, ib.cmd_ready, (i % 2 == 1) ? 2'b10 : 2'b01); end
            @(posedge clk);
            #1;
        end
        ib.cmd_valid = 2'b00;
        checks++;
        if (ib.pos_r !== 8'h72 || ib.pos_c !== 8'h90) begin errors++; $display("FAIL rr_pos got r=%h c=%h required 72/90", ib.pos_r, ib.pos_c); end
        ib.cmd_valid = 2'b10;
        for (int i = 0; i < 13; i++) begin
            ib.cmd_op = (i < 9) ? {3'd3, 3'd0} : {3'd1, 3'd0};
            #1;
            checks++;
            if (ib.cmd_ready !== 2'b10 || ib.cmd_reject !== 2'b00) begin errors++; $display("FAIL walk step %0d got ready=%b reject=%b required 10/00", i, ib.cmd_ready, ib.cmd_reject); end
            @(posedge clk);
            #1;
        end
        ib.cmd_op = {3'd1, 3'd0};
        #1;
        checks++;
        if (ib.cmd_reject !== 2'b10) begin errors++; $display("FAIL onto_player got reject=%b required 10", ib.cmd_reject); end
        @(posedge clk);
        #1;
        ib.cmd_valid = 2'b00;
        checks++;
        if (ib.pos_r !== 8'h32 || ib.pos_c !== 8'h00) begin errors++; $display("FAIL walk_pos got r=%h c=%h required 32/00", ib.pos_r, ib.pos_c); end
    endtask

    task automatic test_back_to_back;
        int tp[6] = '{0, 1, 0, 0, 0, 0};
        logic [2:0] top[6] = '{3'd5, 3'd5, 3'd4, 3'd5, 3'd4, 3'd5};
        logic trj[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int ea[3] = '{7, 8, 10};
        int ei[3] = '{20, 30, 21};
        int eo[3] = '{0, 1, 0};
        int at[4], ix[4], ow[4];
        int q, n;
        logic [1:0] oh;
        q = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            oh = (tp[i] == 1) ? 2'b10 : 2'b01;
            ib.cmd_valid = oh;
            ib.cmd_op = {top[i], top[i]};
            #1;
            checks++;
            if (ib.cmd_ready !== oh || ib.cmd_reject !== (trj[i] ? oh : 2'b00)) begin errors++; $display("FAIL b2b_cmd step %0d got ready=%b reject=%b required %b/%b", i, ib.cmd_ready, ib.cmd_reject, oh, trj[i] ? oh : 2'b00); end
            @(posedge clk);
            #1;
        end
        ib.cmd_valid = 2'b00;
        bm_exp = '0;
        bm_exp[20] = 1'b1;
        bm_exp[21] = 1'b1;
        bm_exp[30] = 1'b1;
        checks++;
        if (ib.bomb_map !== bm_exp) begin errors++; $display("FAIL b2b_map got %h required %h", ib.bomb_map, bm_exp); end
        n = 0;
        at = '{0, 0, 0, 0};
        ix = '{0, 0, 0, 0};
        ow = '{0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            if (ib.explode_valid && n < 4) begin
                at[n] = cyc - q;
                ix[n] = ib.explode_idx;
                ow[n] = ib.explode_owner;
                n++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d required 3", n); end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (at[j] !== ea[j] || ix[j] !== ei[j] || ow[j] !== eo[j]) begin errors++; $display("FAIL b2b_pulse %0d got at=%0d idx=%0d owner=%0d required %0d/%0d/%0d", j, at[j], ix[j], ow[j], ea[j], ei[j], eo[j]); end
        end
        checks++;
        if (ib.bomb_map !== '0) begin errors++; $display("FAIL b2b_clear got %h required 0", ib.bomb_map); end
    endtask

    task automatic test_async_reset;
        logic rej;
        int n;
        send_a(3'd4, rej);
        ib.cmd_valid = 2'b01;
        ib.cmd_op = {3'd0, 3'd5};
        @(posedge clk);
        #1;
        ib.cmd_valid = 2'b00;
        ia.cmd_valid = 2'b01;
        ia.cmd_op = {3'd0, 3'd2};
        rst = 1'b1;
        #1;
        checks++;
        if (ia.pos_r !== 8'h90 || ia.pos_c !== 8'h90) begin errors++; $display("FAIL areset_pos got r=%h c=%h required 90/90", ia.pos_r, ia.pos_c); end
        checks++;
        if (ia.bomb_map !== '0 || ib.bomb_map !== '0) begin errors++; $display("FAIL areset_map got a=%h b=%h required 0", ia.bomb_map, ib.bomb_map); end
        checks++;
        if (ia.cmd_ready !== 2'b00 || ia.explode_idx !== 8'd0 || ia.explode_valid !== 1'b0) begin errors++; $display("FAIL areset_ctrl got ready=%b idx=%0d explode=%b required 00/0/0", ia.cmd_ready, ia.explode_idx, ia.explode_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (ia.cmd_ready !== 2'b01 || ia.cmd_reject !== 2'b00) begin errors++; $display("FAIL areset_cooldown got ready=%b reject=%b required 01/00", ia.cmd_ready, ia.cmd_reject); end
        @(posedge clk);
        #1;
        ia.cmd_valid = 2'b00;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (ia.explode_valid || ib.explode_valid) n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL areset_no_explode got %0d pulses required 0", n); end
        checks++;
        if (ia.pos_r[3:0] !== 4'd1 || ia.pos_c[3:0] !== 4'd0) begin errors++; $display("FAIL areset_move got (%0d,%0d) required (1,0)", ia.pos_r[3:0], ia.pos_c[3:0]); end
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_move();
        test_bomb();
        test_contention();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
